// File: rtl/pe_relay_pkg.sv
// Shared definitions for the PE relay tile: channel indices, default sizing
// and the occupancy-field width helper.
package pe_relay_pkg;
  localparam int CH_EAST  = 0;
  localparam int CH_NORTH = 1;
  localparam int CH_SOUTH = 2;
  localparam int CH_WEST  = 3;

  localparam int DEF_WIDTH = 130;
  localparam int DEF_DEPTH = 4;

  // Occupancy runs 0..DEPTH inclusive, hence one bit beyond the pointer width.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pe_relay_fifo.sv
// One relay channel: DEPTH-entry circular buffer with valid/ready on both
// sides, global freeze via ap_start, registered occupancy.
module pe_relay_fifo
  import pe_relay_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ap_start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             full, empty, push, pop;

  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);

  // in_ready looks only at the registered count, so no path from out_ready.
  assign in_ready  = ap_start & ~full & reset;
  assign out_valid = ap_start & ~empty & reset;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = (empty | ~reset) ? '0 : mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pe_relay_hs.sv
// PE slot relay: NUM_CH independent elastic channels (E/N/S/W), each a
// WIDTH-bit valid/ready stream with its own buffer and occupancy report.
module pe_relay_hs
  import pe_relay_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LVL_W  = lvl_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*LVL_W-1:0] level
);
  if (NUM_CH < 1 || NUM_CH > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
    $error("pe_relay_hs: unsupported NUM_CH=%0d / DEPTH=%0d", NUM_CH, DEPTH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pe_relay_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .ap_start  (ap_start),
      .in_data   (in_data[c*WIDTH +: WIDTH]),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .out_data  (out_data[c*WIDTH +: WIDTH]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .level     (level[c*LVL_W +: LVL_W])
    );
  end
endmodule

// File: tb/tb_pe_relay_hs.sv
// Directed bench for pe_relay_hs: reset, latency, back-pressure, wrap,
// ap_start freeze and mid-stream reset, checked with immediate assertions.
module tb_pe_relay_hs;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 130;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    ap_start;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*LVL_W-1:0] level;

  int checks = 0;
  int errors = 0;

  pe_relay_hs #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int c, input logic [WIDTH-1:0] d, input logic v);
    in_data[c*WIDTH +: WIDTH] = d;
    in_valid[c] = v;
  endtask

  function automatic logic [WIDTH-1:0] od(input int c);
    return out_data[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] lv(input int c);
    return WIDTH'(level[c*LVL_W +: LVL_W]);
  endfunction

  initial begin
    reset     = 1'b0;
    ap_start  = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = '0;

    // Reset held 3 cycles, then idle
    repeat (3) tick();
    chk("rst_in_ready", WIDTH'(in_ready), '0);
    chk("rst_out_valid", WIDTH'(out_valid), '0);
    reset = 1'b1;
    settle();
    chk("idle_out_valid", WIDTH'(out_valid), '0);
    chk("idle_in_ready", WIDTH'(in_ready), WIDTH'(4'hF));
    chk("idle_level", WIDTH'(level), '0);
    for (int c = 0; c < NUM_CH; c++) chk("idle_out_data", od(c), '0);

    // Single word on ch0: no flow-through, visible one cycle later
    out_ready = 4'hF;
    put(0, 130'h2A, 1'b1);
    settle();
    chk("lat_in_ready0", WIDTH'(in_ready[0]), 1);
    chk("lat_no_flow", WIDTH'(out_valid[0]), 0);
    tick();
    put(0, '0, 1'b0);
    settle();
    chk("lat_valid0", WIDTH'(out_valid[0]), 1);
    chk("lat_data0", od(0), 130'h2A);
    chk("lat_level0", lv(0), 1);
    chk("lat_others", WIDTH'(out_valid[3:1]), 0);
    tick();
    chk("lat_drain_valid", WIDTH'(out_valid[0]), 0);
    chk("lat_drain_level", lv(0), 0);
    chk("lat_drain_data", od(0), 0);

    // Fill ch1 with out_ready low
    out_ready = 4'b1101;
    for (int w = 1; w <= 4; w++) begin
      put(1, WIDTH'(w), 1'b1);
      settle();
      chk("fill_in_ready", WIDTH'(in_ready[1]), 1);
      tick();
    end
    put(1, 130'h5, 1'b1);
    settle();
    chk("full_in_ready", WIDTH'(in_ready[1]), 0);
    chk("full_level", lv(1), 4);
    chk("full_head", od(1), 1);
    out_ready = 4'hF;
    settle();
    chk("full_pop_no_ready", WIDTH'(in_ready[1]), 0);
    tick();                              // pops 1, nothing accepted
    chk("bp_level3", lv(1), 3);
    chk("bp_head2", od(1), 2);
    chk("bp_ready_again", WIDTH'(in_ready[1]), 1);
    tick();                              // pops 2, pushes 5
    put(1, 130'h6, 1'b1);
    settle();
    chk("bp_head3", od(1), 3);
    tick();                              // pops 3, pushes 6
    put(1, '0, 1'b0);
    settle();
    chk("bp_level_stream", lv(1), 3);
    for (int w = 4; w <= 6; w++) begin
      chk("bp_order", od(1), WIDTH'(w));
      chk("bp_valid", WIDTH'(out_valid[1]), 1);
      tick();
    end
    chk("bp_empty", WIDTH'(out_valid[1]), 0);
    chk("bp_empty_level", lv(1), 0);

    // Streaming on ch2 across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      put(2, WIDTH'(32'h100 + i), 1'b1);
      settle();
      if (i == 0) begin
        chk("strm_first_valid", WIDTH'(out_valid[2]), 0);
      end else begin
        chk("strm_valid", WIDTH'(out_valid[2]), 1);
        chk("strm_data", od(2), WIDTH'(32'h100 + i - 1));
        chk("strm_level", lv(2), 1);
      end
      tick();
    end
    put(2, '0, 1'b0);
    settle();
    chk("strm_last", od(2), 130'h113);
    tick();
    chk("strm_drained", lv(2), 0);

    // ap_start pause with 2 words on ch3
    out_ready = 4'b0111;
    put(3, 130'hA1, 1'b1);
    tick();
    put(3, 130'hA2, 1'b1);
    tick();
    chk("pause_pre_level", lv(3), 2);
    ap_start  = 1'b0;
    out_ready = 4'hF;
    put(3, 130'hA3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("pause_in_ready", WIDTH'(in_ready[3]), 0);
      chk("pause_out_valid", WIDTH'(out_valid[3]), 0);
      chk("pause_level", lv(3), 2);
      tick();
    end
    ap_start = 1'b1;
    settle();
    chk("resume_valid", WIDTH'(out_valid[3]), 1);
    chk("resume_A1", od(3), 130'hA1);
    tick();                              // pops A1, pushes A3
    put(3, 130'hA4, 1'b1);
    settle();
    chk("resume_A2", od(3), 130'hA2);
    tick();                              // pops A2, pushes A4
    put(3, '0, 1'b0);
    settle();
    chk("resume_A3", od(3), 130'hA3);
    tick();
    chk("resume_A4", od(3), 130'hA4);
    tick();
    chk("resume_empty", lv(3), 0);

    // Reset mid-stream on ch0 with 3 words buffered
    out_ready = 4'b1110;
    for (int w = 0; w < 3; w++) begin
      put(0, WIDTH'(8'h11 + w), 1'b1);
      tick();
    end
    put(0, '0, 1'b0);
    settle();
    chk("mid_level3", lv(0), 3);
    reset = 1'b0;
    settle();
    chk("mid_rst_in_ready", WIDTH'(in_ready[0]), 0);
    chk("mid_rst_out_valid", WIDTH'(out_valid[0]), 0);
    chk("mid_rst_out_data", od(0), 0);
    tick();
    reset = 1'b1;
    settle();
    chk("mid_level0", lv(0), 0);
    chk("mid_valid0", WIDTH'(out_valid[0]), 0);
    put(0, 130'h55, 1'b1);
    tick();
    put(0, '0, 1'b0);
    out_ready = 4'hF;
    settle();
    chk("mid_new_valid", WIDTH'(out_valid[0]), 1);
    chk("mid_new_data", od(0), 130'h55);
    chk("mid_new_level", lv(0), 1);
    tick();
    chk("mid_final_level", lv(0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_relay_hs.md
Name: pe_relay_hs

Overview:
- Parametrised successor to the fixed-width PE pass-through tile.
- Relays NUM_CH independent channels (E/N/S/W order, channel 0 = east) through the PE slot.
- Each channel carries WIDTH-bit words with a valid/ready handshake and a DEPTH-entry elastic buffer, so it can absorb back-pressure.
- ap_start freezes all transfers without losing data; each channel reports its buffer occupancy.

Parameters:
- NUM_CH, 4, channel count (1..4); channel c occupies bit slice [c*WIDTH +: WIDTH].
- WIDTH, 130, data bits per channel.
- DEPTH, 4, buffer entries per channel; power of 2, >= 2.
- LVL_W, $clog2(DEPTH)+1, width of each occupancy field.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- ap_start  input  1  global enable; 0 = freeze all channels.
- in_data  input  NUM_CH*WIDTH  upstream words.
- in_valid  input  NUM_CH  upstream word valid, per channel.
- in_ready  output  NUM_CH  buffer accepts word, per channel.
- out_data  output  NUM_CH*WIDTH  downstream words.
- out_valid  output  NUM_CH  downstream word valid, per channel.
- out_ready  input  NUM_CH  downstream accepts word, per channel.
- level  output  NUM_CH*LVL_W  per-channel occupancy, 0..DEPTH.

Behaviour:
- Channels are fully independent. No cross-channel coupling except through ap_start and reset.
- Per channel c:
  - in_ready[c] = ap_start & ~full[c] & reset.
  - out_valid[c] = ap_start & ~empty[c] & reset.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage is a circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits wide, plus a count register of LVL_W bits.
- full = (count == DEPTH); empty = (count == 0).
- On push: mem[wr_ptr] <= in_data slice, and wr_ptr increments, wrapping DEPTH-1 -> 0.
- On pop: rd_ptr increments with the same wrap.
- Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
- out_data slice = empty ? 0 : mem[rd_ptr]. This is a combinational read of registered storage; no bypass path.
- Latency: a word pushed at edge t appears with out_valid at cycle t+1 at the earliest. There is no same-cycle flow-through when the buffer is empty.
- Full buffer: in_ready is low, even if a pop happens in the same cycle. This keeps in_ready free of any combinational path from out_ready.
- Throughput: one word per cycle per channel in steady state once count >= 1.
- level slice = count, registered.
- ap_start = 0:
  - in_ready and out_valid are forced low, so no push or pop occurs.
  - mem, pointers and count hold; level keeps showing the held count.
  - On return to 1, transfers resume with no loss or duplication.
- reset = 0 (sampled at the edge):
  - Pointers and count clear to 0; mem contents are not cleared.
  - In the same cycle, in_ready = 0, out_valid = 0, out_data = 0 and level = 0 (level from the next edge).
  - Reset mid-stream discards buffered words; reset takes priority over push and pop.
- Out-of-range combinations (NUM_CH > 4, DEPTH not a power of 2) are rejected by an elaboration-time check.

Decomposition:
- Shared package pe_relay_pkg holds:
  - channel index constants CH_EAST=0, CH_NORTH=1, CH_SOUTH=2, CH_WEST=3;
  - default WIDTH and DEPTH;
  - an LVL_W helper function.
- Sub-module pe_relay_fifo implements one channel (params WIDTH, DEPTH). The top instantiates NUM_CH copies in a generate loop and shares ap_start and reset.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, then release with ap_start=1 and no valid. Required: out_valid=0, out_data=0, level=0, in_ready=all 1s.
- Single word latency: on ch0 drive in_data=0x2A for one cycle, out_ready=1. Required: out_valid[0]=1 with 0x2A exactly 1 cycle later, then level returns to 0; other channels stay idle.
- Fill and back-pressure: DEPTH=4, push 0x1..0x6 on ch1 with out_ready=0. Required: words 1..4 accepted, in_ready[1]=0 after the 4th, level=4. Then set out_ready=1. Required: output order 1,2,3,4, then 5,6 accepted and delivered in order.
- Wrap-around under streaming: continuous push and pop of an incrementing count for 20 cycles on ch2. Required: no gaps after the first word, level steady at 1, data in order across pointer wrap.
- ap_start pause: with 2 words buffered on ch3, drop ap_start for 5 cycles while in_valid=1 and out_ready=1. Required: in_ready=0, out_valid=0, level stays 2. After ap_start returns, both words and then new words emerge in order.
- Reset mid-stream: with level=3 on ch0, pulse reset=0 for 1 cycle. Required: level=0 and out_valid=0 next cycle; the next pushed word 0x55 emerges first.
